// File: rtl/i_scan_ctrl_if.sv
// Output stream of the raster-scan controller: one pixel coordinate and
// address per valid/ready handshake.
interface i_scan_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 13
);
    logic              out_valid;
    logic              out_ready;
    logic [DIM_W-1:0]  pix_col;
    logic [DIM_W-1:0]  pix_row;
    logic [ADDR_W-1:0] pix_addr;
    logic              eol;
    logic              eof;

    modport master (
        output out_valid,
        output pix_col,
        output pix_row,
        output pix_addr,
        output eol,
        output eof,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  pix_col,
        input  pix_row,
        input  pix_addr,
        input  eol,
        input  eof,
        output out_ready
    );
endinterface

// File: rtl/i_scan_ctrl.sv
// Raster-scan controller: walks col/row over one frame and presents each
// pixel's coordinate and address; all outputs come straight from flops.
module i_scan_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 13
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  img_width,
    input  logic [DIM_W-1:0]  img_height,
    input  logic [ADDR_W-1:0] base_addr,
    i_scan_ctrl_if.master     out_if,
    output logic              busy,
    output logic              frame_done,
    output logic              cfg_err
);
    localparam int LB_W = 2 * DIM_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state;
    logic [DIM_W-1:0]  r_col, w_col;
    logic [DIM_W-1:0]  r_row, w_row;
    logic [LB_W-1:0]   r_line_base, w_line_base;
    logic [DIM_W-1:0]  r_width, w_width;
    logic [DIM_W-1:0]  r_height, w_height;
    logic [ADDR_W-1:0] r_base, w_base;
    logic              r_valid, w_valid;
    logic              r_eol, w_eol;
    logic              r_eof, w_eof;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic              r_busy, w_busy;
    logic              r_frame_done, w_frame_done;
    logic              r_cfg_err, w_cfg_err;
    logic              w_hs;
    logic              w_last_col;
    logic              w_last_row;

    // State and registered outputs; clear wins over everything
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= ST_IDLE;
            r_col        <= {DIM_W{1'b0}};
            r_row        <= {DIM_W{1'b0}};
            r_line_base  <= {LB_W{1'b0}};
            r_width      <= {DIM_W{1'b0}};
            r_height     <= {DIM_W{1'b0}};
            r_base       <= {ADDR_W{1'b0}};
            r_valid      <= 1'b0;
            r_eol        <= 1'b0;
            r_eof        <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_col        <= w_col;
            r_row        <= w_row;
            r_line_base  <= w_line_base;
            r_width      <= w_width;
            r_height     <= w_height;
            r_base       <= w_base;
            r_valid      <= w_valid;
            r_eol        <= w_eol;
            r_eof        <= w_eof;
            r_addr       <= w_addr;
            r_busy       <= w_busy;
            r_frame_done <= w_frame_done;
            r_cfg_err    <= w_cfg_err;
        end
    end

    // Next-state logic; outputs are derived from the next-state values so they register cleanly
    always_comb begin
        w_state     = r_state;
        w_col       = r_col;
        w_row       = r_row;
        w_line_base = r_line_base;
        w_width     = r_width;
        w_height    = r_height;
        w_base      = r_base;
        w_cfg_err   = 1'b0;
        w_hs        = r_valid & out_if.out_ready;
        w_last_col  = (r_col == (r_width - DIM_W'(1)));
        w_last_row  = (r_row == (r_height - DIM_W'(1)));

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((img_width != {DIM_W{1'b0}}) && (img_height != {DIM_W{1'b0}})) begin
                        w_state     = ST_SCAN;
                        w_width     = img_width;
                        w_height    = img_height;
                        w_base      = base_addr;
                        w_col       = {DIM_W{1'b0}};
                        w_row       = {DIM_W{1'b0}};
                        w_line_base = {LB_W{1'b0}};
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (abort) begin
                    w_state     = ST_IDLE;
                    w_col       = {DIM_W{1'b0}};
                    w_row       = {DIM_W{1'b0}};
                    w_line_base = {LB_W{1'b0}};
                end else if (w_hs) begin
                    if (!w_last_col) begin
                        w_col = r_col + DIM_W'(1);
                    end else if (!w_last_row) begin
                        w_col       = {DIM_W{1'b0}};
                        w_row       = r_row + DIM_W'(1);
                        w_line_base = r_line_base + {{DIM_W{1'b0}}, r_width};
                    end else begin
                        w_state     = ST_DONE;
                        w_col       = {DIM_W{1'b0}};
                        w_row       = {DIM_W{1'b0}};
                        w_line_base = {LB_W{1'b0}};
                    end
                end else begin
                    w_state = ST_SCAN;
                end
            end
            ST_DONE: begin
                w_state = ST_IDLE;
            end
            default: begin
                w_state     = ST_IDLE;
                w_col       = {DIM_W{1'b0}};
                w_row       = {DIM_W{1'b0}};
                w_line_base = {LB_W{1'b0}};
            end
        endcase

        w_valid      = (w_state == ST_SCAN);
        w_eol        = w_valid && (w_col == (w_width - DIM_W'(1)));
        w_eof        = w_eol && (w_row == (w_height - DIM_W'(1)));
        w_addr       = w_valid ? (w_base + ADDR_W'(w_line_base) + ADDR_W'(w_col)) : {ADDR_W{1'b0}};
        w_busy       = (w_state != ST_IDLE);
        w_frame_done = (w_state == ST_DONE);
    end

    assign out_if.out_valid = r_valid;
    assign out_if.pix_col   = r_col;
    assign out_if.pix_row   = r_row;
    assign out_if.pix_addr  = r_addr;
    assign out_if.eol       = r_eol;
    assign out_if.eof       = r_eof;
    assign busy             = r_busy;
    assign frame_done       = r_frame_done;
    assign cfg_err          = r_cfg_err;
endmodule

// File: doc/i_scan_ctrl.md
Name: i_scan_ctrl

Overview:
- Raster-scan controller that sequences column/row indexing for one image frame and emits one pixel coordinate and address per accepted transfer.
- Sits between the frame-level control FSM (start, dimensions, base address) and the pixel fetch path (memory read request / downstream filter).
- Uses a valid/ready handshake on its output.
- Column indexing is 0..img_width-1, wrapping on the last column. This matches the existing column-counter convention: rollover value = width.

Parameters:
- ADDR_W, 32, width of the base address and pixel address (byte-agnostic pixel index space)
- DIM_W, 13, width of img_width, img_height, pix_col and pix_row (max dimension 8191)

Ports:
- clk  in  1  system clock, all logic on posedge
- clear  in  1  reset, synchronous, active-high; overrides every other input
- start  in  1  1-cycle request to begin a frame; sampled only in IDLE
- abort  in  1  terminate the current frame; sampled in SCAN
- img_width  in  DIM_W  columns per row; latched on accepted start
- img_height  in  DIM_W  rows per frame; latched on accepted start
- base_addr  in  ADDR_W  address of pixel (0,0); latched on accepted start
- out_ready  in  1  downstream accepts the current coordinate
- out_valid  out  1  pix_col, pix_row and pix_addr are valid
- pix_col  out  DIM_W  current column index
- pix_row  out  DIM_W  current row index
- pix_addr  out  ADDR_W  base + row*width + col, modulo 2^ADDR_W
- eol  out  1  out_valid and pix_col == width-1
- eof  out  1  eol and pix_row == height-1
- busy  out  1  state != IDLE
- frame_done  out  1  1-cycle pulse after the last pixel is accepted
- cfg_err  out  1  1-cycle pulse when start arrives with width==0 or height==0

Behaviour:
- Reset (clear=1): state=IDLE. Every output is 0. Internal col, row, line_base and latched config are 0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start=1 with both dims nonzero: latch width, height and base; col=row=0; line_base=0; go to SCAN.
  - out_valid rises the cycle after start (latency 1).
  - start=1 with width==0 or height==0: cfg_err=1 for the next cycle; stay IDLE.
- SCAN:
  - out_valid=1.
  - Handshake = out_valid & out_ready.
  - No handshake: col, row and pix_addr hold exactly (stable under backpressure).
  - Handshake and col != width-1: col+1.
  - Handshake and col == width-1, row != height-1: col=0; row+1; line_base += width.
  - Handshake on eof: go to DONE. out_valid=0 next cycle.
- DONE: frame_done=1 for exactly this cycle, out_valid=0, go to IDLE.
  - Earliest next start accepted is the cycle after DONE (in IDLE).
- abort:
  - In SCAN, abort has priority over a same-cycle handshake.
  - Next state IDLE, out_valid=0, no frame_done, counters reset to 0.
  - abort in IDLE or DONE is ignored.
- start while busy: ignored. Latched config never changes mid-frame, even if the inputs change.
- Address arithmetic:
  - line_base is 2*DIM_W bits wide (26), so no multiplier is needed.
  - pix_addr = base + zero-extended line_base + zero-extended col, truncated to ADDR_W.
  - pix_addr is consistent with pix_col/pix_row in the same cycle.
- 1-wide frame: every pixel is eol. 1x1 frame: the first pixel is both eol and eof.
- clear mid-frame: the next cycle is IDLE with all outputs 0. No frame_done.

Test Plan:
- Normal scan: width=3, height=2, base=0x100, out_ready=1, start pulse.
  - out_valid from the next cycle.
  - Addresses 0x100..0x105 in order; (col,row) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - eol on cols 2; eof on 0x105.
  - frame_done 1 cycle after eof; busy low after that.
- Backpressure: same frame, out_ready low for 3 cycles at (1,0).
  - Outputs held at col=1, row=0, addr=0x101 for all 3 cycles.
  - Sequence resumes unchanged; total accepted = 6.
- Abort: width=10, height=10; abort asserted at (4,2) together with out_ready=1.
  - Next cycle out_valid=0, busy=0, no frame_done.
  - A new start yields (0,0) at base.
- Config error: start with width=0, height=5.
  - cfg_err pulses 1 cycle; busy stays 0; no out_valid.
  - Same for width=5, height=0.
- Boundaries:
  - 1x1 frame at base=0xFFFFFFFF: single pixel with eol=eof=1 and addr 0xFFFFFFFF, then frame_done.
  - width=8191, height=2, base=0: last pixel col=8190, row=1, addr=16381. Address increments by 1 across the row wrap.
- clear mid-frame: assert clear at (5,3) of a 10x10 frame.
  - Next cycle all outputs 0, state IDLE.
  - A following start runs a complete 10x10 frame: 100 handshakes, then frame_done.
